// File: rtl/inverse_lerp.sv
// Inverse linear interpolator: ratio = (x-a)/(b-a) in QU0.r via a restoring divider.
// Define INVERSE_LERP_ROUND_EN for round-half-up on the ratio (one extra guard-bit iteration).
module inverse_lerp #(
    parameter int INPUT_BITS      = 16,
    parameter int RATIO_FRAC_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INPUT_BITS-1:0]      a,
    input  logic [INPUT_BITS-1:0]      b,
    input  logic [INPUT_BITS-1:0]      x,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RATIO_FRAC_BITS-1:0] ratio,
    output logic                       clamped,
    output logic                       degenerate
);

`ifdef INVERSE_LERP_ROUND_EN
    localparam int ITERS = RATIO_FRAC_BITS + 1;
`else
    localparam int ITERS = RATIO_FRAC_BITS;
`endif
    localparam int CNT_W = $clog2(ITERS + 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t state, state_nxt;

    logic signed [INPUT_BITS:0]   num, den;
    logic [INPUT_BITS-1:0]        num_mag, den_mag;
    logic                         signs_differ, go_div;
    logic [INPUT_BITS-1:0]        rem, den_q, rem_nxt;
    logic [ITERS-1:0]             quo, quo_nxt;
    logic [CNT_W-1:0]             cnt;
    logic                         qbit;
    logic [RATIO_FRAC_BITS-1:0]   ratio_q;
    logic                         clamped_q, degen_q;

    function automatic logic [INPUT_BITS-1:0] mag(input logic signed [INPUT_BITS:0] v);
        return v[INPUT_BITS] ? INPUT_BITS'(-v) : INPUT_BITS'(v);
    endfunction

    // One restoring step: returns {quotient bit, next remainder}.
    function automatic logic [INPUT_BITS:0] div_step(input logic [INPUT_BITS-1:0] r,
                                                     input logic [INPUT_BITS-1:0] d);
        logic [INPUT_BITS:0] r2;
        r2 = {r, 1'b0};
        if (r2 >= {1'b0, d})
            return {1'b1, INPUT_BITS'(r2 - {1'b0, d})};
        else
            return {1'b0, r2[INPUT_BITS-1:0]};
    endfunction

    // Converts the raw quotient to {clamped, ratio}.
    function automatic logic [RATIO_FRAC_BITS:0] finish_quo(input logic [ITERS-1:0] q);
`ifdef INVERSE_LERP_ROUND_EN
        logic [RATIO_FRAC_BITS:0] s;
        s = {1'b0, q[ITERS-1:1]} + (RATIO_FRAC_BITS+1)'(q[0]);
        if (s[RATIO_FRAC_BITS])
            return {1'b1, {RATIO_FRAC_BITS{1'b1}}};
        else
            return {1'b0, s[RATIO_FRAC_BITS-1:0]};
`else
        return {1'b0, q};
`endif
    endfunction

    assign num          = $signed({1'b0, x}) - $signed({1'b0, a});
    assign den          = $signed({1'b0, b}) - $signed({1'b0, a});
    assign num_mag      = mag(num);
    assign den_mag      = mag(den);
    assign signs_differ = num[INPUT_BITS] ^ den[INPUT_BITS];
    assign go_div       = (den != '0) && (num != '0) && !signs_differ && (num_mag < den_mag);

    assign {qbit, rem_nxt} = div_step(rem, den_q);
    assign quo_nxt         = (quo << 1) | ITERS'(qbit);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = go_div ? DIV : DONE;
            DIV:  if (cnt == CNT_W'(1)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Result flags are classified on accept; the divider only fills in the case-5 ratio.
    always_ff @(posedge clk) begin
        if (reset) begin
            ratio_q   <= '0;
            clamped_q <= 1'b0;
            degen_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ratio_q   <= '0;
                    clamped_q <= 1'b0;
                    degen_q   <= 1'b0;
                    if (den == '0)
                        degen_q <= 1'b1;
                    else if (num == '0)
                        clamped_q <= 1'b0;
                    else if (signs_differ)
                        clamped_q <= 1'b1;
                    else if (num_mag >= den_mag) begin
                        ratio_q   <= '1;
                        clamped_q <= 1'b1;
                    end
                end
                DIV: if (cnt == CNT_W'(1))
                    {clamped_q, ratio_q} <= finish_quo(quo_nxt);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            rem   <= num_mag;
            den_q <= den_mag;
            quo   <= '0;
            cnt   <= CNT_W'(ITERS);
        end else if (state == DIV) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign ratio      = ratio_q;
    assign clamped    = clamped_q;
    assign degenerate = degen_q;

endmodule

// File: tb/tb_inverse_lerp.sv
// Scoreboard bench for inverse_lerp: directed vectors plus a randomised in-span sweep.
module tb_inverse_lerp;
    localparam int IB = 16;
    localparam int RF = 8;
    localparam int RMAX = (1 << RF) - 1;
`ifdef INVERSE_LERP_ROUND_EN
    localparam int LDIV = RF + 2;
`else
    localparam int LDIV = RF + 1;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [IB-1:0] a, b, x;
    logic          out_valid;
    logic          out_ready;
    logic [RF-1:0] ratio;
    logic          clamped;
    logic          degenerate;

    inverse_lerp #(.INPUT_BITS(IB), .RATIO_FRAC_BITS(RF)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .x(x), .out_valid(out_valid), .out_ready(out_ready),
        .ratio(ratio), .clamped(clamped), .degenerate(degenerate)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ratio;
        int clamped;
        int degen;
        int lat;
        int acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int ai, input int bi, input int xi);
        exp_t e;
        int n, d, qq, r;
        e = '{0, 0, 0, 1, 0};
        n = xi - ai;
        d = bi - ai;
        if (d == 0) begin
            e.degen = 1;
        end else if (n == 0) begin
        end else if ((n < 0) != (d < 0)) begin
            e.clamped = 1;
        end else begin
            n = (n < 0) ? -n : n;
            d = (d < 0) ? -d : d;
            if (n >= d) begin
                e.ratio = RMAX;
                e.clamped = 1;
            end else begin
                e.lat = LDIV;
`ifdef INVERSE_LERP_ROUND_EN
                qq = (n * (1 << (RF + 1))) / d;
                r  = (qq >> 1) + (qq & 1);
                if (r > RMAX) begin
                    e.ratio = RMAX;
                    e.clamped = 1;
                end else
                    e.ratio = r;
`else
                qq = (n * (1 << RF)) / d;
                r  = qq;
                e.ratio = r;
`endif
            end
        end
        return e;
    endfunction

    // Monitor: compares every consumed output against the scoreboard head.
    logic prev_valid = 1'b0;
    int   rise_cyc = 0;
    int   hold_ratio, hold_clamped, hold_degen;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_valid = 1'b0;
        end else if (out_valid) begin
            if (!prev_valid) begin
                rise_cyc     = cyc;
                hold_ratio   = int'(ratio);
                hold_clamped = int'(clamped);
                hold_degen   = int'(degenerate);
            end else begin
                chk("hold_ratio", int'(ratio), hold_ratio);
                chk("hold_clamped", int'(clamped), hold_clamped);
                chk("hold_degenerate", int'(degenerate), hold_degen);
            end
            chk("in_ready_while_done", int'(in_ready), 0);
            prev_valid = 1'b1;
            if (out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_output", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("ratio", int'(ratio), e.ratio);
                    chk("clamped", int'(clamped), e.clamped);
                    chk("degenerate", int'(degenerate), e.degen);
                    chk("latency", rise_cyc - e.acc + 1, e.lat);
                end
                prev_valid = 1'b0;
            end
        end else begin
            prev_valid = 1'b0;
        end
    end

    // Called at posedge+1; issues one transaction and optionally records its expectation.
    task automatic send(input int ai, input int bi, input int xi, input exp_t e, input bit push);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 0, 1);
            return;
        end
        a = IB'(ai); b = IB'(bi); x = IB'(xi);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        e.acc = cyc;
        if (push) q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_pending", q.size(), 0);
    endtask

    typedef struct {
        int a, b, x, ratio, clamped, degen, lat;
    } vec_t;

    vec_t dirv[$];

    initial begin
        exp_t e;
        int   lo, hi, ai, bi, xi, n;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; x = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_ratio", int'(ratio), 0);
        chk("rst_clamped", int'(clamped), 0);
        chk("rst_degenerate", int'(degenerate), 0);
        reset = 1'b0;

        dirv.push_back('{0, 256, 128, 8'h80, 0, 0, LDIV});
        dirv.push_back('{1000, 0, 750, 8'h40, 0, 0, LDIV});
        dirv.push_back('{100, 200, 50, 8'h00, 1, 0, 1});
        dirv.push_back('{0, 100, 200, 8'hFF, 1, 0, 1});
        dirv.push_back('{0, 100, 100, 8'hFF, 1, 0, 1});
        dirv.push_back('{5, 5, 9, 0, 0, 1, 1});
        dirv.push_back('{10, 20, 10, 0, 0, 0, 1});
`ifdef INVERSE_LERP_ROUND_EN
        dirv.push_back('{0, 1000, 999, 8'hFF, 1, 0, LDIV});
        dirv.push_back('{0, 1000, 1, 0, 0, 0, LDIV});
`else
        dirv.push_back('{0, 1000, 999, 8'hFF, 0, 0, LDIV});
        dirv.push_back('{0, 1000, 1, 0, 0, 0, LDIV});
`endif
        foreach (dirv[i]) begin
            e = '{dirv[i].ratio, dirv[i].clamped, dirv[i].degen, dirv[i].lat, 0};
            send(dirv[i].a, dirv[i].b, dirv[i].x, e, 1'b1);
        end
        drain();

        // Backpressure with stray in_valid pulses while busy.
        out_ready = 1'b0;
`ifdef INVERSE_LERP_ROUND_EN
        e = '{171, 0, 0, LDIV, 0};
`else
        e = '{170, 0, 0, LDIV, 0};
`endif
        send(0, 3, 2, e, 1'b1);
        a = 16'd0; b = 16'd10; x = 16'd5; in_valid = 1'b1;
        repeat (3) begin
            chk("in_ready_during_div", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_out_valid_seen", int'(out_valid), 1);
        in_valid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_out_valid_held", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset on the fourth DIV cycle aborts the division.
        e = '{0, 0, 0, LDIV, 0};
        send(0, 256, 1, e, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_ratio", int'(ratio), 0);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_stale", int'(out_valid), 0);

        // Randomised in-span sweep, either direction.
        for (int i = 0; i < 600; i++) begin
            ai = int'($urandom_range(0, 65535));
            bi = int'($urandom_range(0, 65535));
            lo = (ai < bi) ? ai : bi;
            hi = (ai < bi) ? bi : ai;
            xi = lo + int'($urandom_range(0, hi - lo));
            send(ai, bi, xi, model(ai, bi, xi), 1'b1);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t required=<2000000", $time);
        $fatal(1, "timeout");
    end
endmodule
